// File: rtl/clock_pkg.sv
// Shared constants for the clock user-input path: mode encoding,
// the default mode count and the up/down auto-repeat state encoding.
package clock_pkg;

  typedef logic [2:0] mode_t;

  localparam int NUM_MODES = 7;

  localparam mode_t MODE_RUN  = 3'd0;
  localparam mode_t MODE_SEC  = 3'd1;
  localparam mode_t MODE_MIN  = 3'd2;
  localparam mode_t MODE_HOUR = 3'd3;
  localparam mode_t MODE_DAY  = 3'd4;
  localparam mode_t MODE_MONT = 3'd5;
  localparam mode_t MODE_YEAR = 3'd6;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  // Next edit field; the last field wraps back to run.
  function automatic mode_t mode_wrap_inc(input mode_t m, input int num_modes);
    if (int'(m) >= num_modes - 1) begin
      return MODE_RUN;
    end
    return m + 3'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push-button.
// rise/fall are registered one-cycle flags issued on the edge the debounced level flips.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          rise_reg;
  logic          fall_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      // Any agreement restarts the count, so only an unbroken run flips the level.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_TC) begin
        cnt_reg   <= '0;
        level_reg <= sync2_reg;
        rise_reg  <= sync2_reg;
        fall_reg  <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/button_input_ctrl.sv
// Clock user-input front end: debounced mode selector plus up/down
// increment pulses with hold-to-auto-repeat for the time/date counters.
module button_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int NUM_MODES       = clock_pkg::NUM_MODES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode_raw,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  output logic [2:0] mode,
  output logic       btn_up,
  output logic       btn_down
);

  import clock_pkg::*;

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] DELAY_TC  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_TC = TW'(REPEAT_PERIOD - 1);

  // Index 0 = mode, 1 = up, 2 = down.
  logic [2:0] raw_vec;
  logic [2:0] lvl;
  logic [2:0] rise;
  logic [2:0] fall;

  assign raw_vec = {btn_down_raw, btn_up_raw, btn_mode_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_deb
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw_vec[gi]),
        .level(lvl[gi]),
        .rise (rise[gi]),
        .fall (fall[gi])
      );
    end
  endgenerate

  // Mode acts only on presses.
  logic unused_mode_bits;
  assign unused_mode_bits = lvl[0] ^ fall[0];

  logic  mode_press;
  logic  both_held;
  mode_t mode_reg;

  assign mode_press = rise[0];
  assign both_held  = lvl[1] & lvl[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg <= MODE_RUN;
    end else if (mode_press) begin
      mode_reg <= mode_wrap_inc(mode_reg, NUM_MODES);
    end
  end

  // One repeat FSM per direction: index 0 = up, 1 = down.
  logic [1:0] pulse;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rep
      logic [1:0]    state_reg;
      logic [1:0]    state_next;
      logic [TW-1:0] timer_reg;
      logic [TW-1:0] timer_next;
      logic          pulse_next;

      always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        pulse_next = 1'b0;
        // A held button parked in IDLE needs a fresh press to pulse again.
        if (fall[gi+1] || both_held || mode_press) begin
          state_next = IDLE;
          timer_next = '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (rise[gi+1]) begin
                pulse_next = 1'b1;
                state_next = DELAY;
                timer_next = '0;
              end
            end
            DELAY: begin
              if (timer_reg == DELAY_TC) begin
                pulse_next = 1'b1;
                state_next = REPEAT;
                timer_next = '0;
              end else begin
                timer_next = timer_reg + 1'b1;
              end
            end
            REPEAT: begin
              if (timer_reg == PERIOD_TC) begin
                pulse_next = 1'b1;
                timer_next = '0;
              end else begin
                timer_next = timer_reg + 1'b1;
              end
            end
            default: begin
              state_next = IDLE;
              timer_next = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          timer_reg <= '0;
        end else begin
          state_reg <= state_next;
          timer_reg <= timer_next;
        end
      end

      assign pulse[gi] = pulse_next;
    end
  endgenerate

  // Pulses are decoded from flopped event flags, timers and mode only.
  logic edit_active;
  assign edit_active = (mode_reg != MODE_RUN);

  assign mode     = mode_reg;
  assign btn_up   = pulse[0] & edit_active;
  assign btn_down = pulse[1] & edit_active;

endmodule

// File: tb/tb_button_input_ctrl.sv
// Directed bench for button_input_ctrl with short debounce/repeat timings.
module tb_button_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_mode_raw = 1'b0;
  logic       btn_up_raw = 1'b0;
  logic       btn_down_raw = 1'b0;
  logic [2:0] mode;
  logic       btn_up;
  logic       btn_down;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5),
    .NUM_MODES      (7)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_mode_raw(btn_mode_raw),
    .btn_up_raw  (btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .mode        (mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down)
  );

  // Stimulus only: one 10-cycle mode press and 10-cycle release, from a negedge.
  task automatic press_mode();
    btn_mode_raw = 1'b1;
    repeat (10) @(negedge clk);
    btn_mode_raw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({mode, btn_up, btn_down} !== 5'b0) begin
      $display("FAIL reset_async: got mode=%0d up=%b down=%b expected 0/0/0", mode, btn_up, btn_down);
      errors++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mode, btn_up, btn_down} !== 5'b0) begin
      $display("FAIL reset_release: got mode=%0d up=%b down=%b expected 0/0/0", mode, btn_up, btn_down);
      errors++;
    end
    $display("reset: mode=%0d up=%b down=%b", mode, btn_up, btn_down);
  endtask

  task automatic test_mode_cycle();
    logic [2:0] old_m;
    logic [2:0] new_m;
    old_m = 3'd0;
    for (int p = 0; p < 8; p++) begin
      new_m = (old_m == 3'd6) ? 3'd0 : old_m + 3'd1;
      btn_mode_raw = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (k == 10) btn_mode_raw = 1'b0;
        checks++;
        if ({btn_up, btn_down} !== 2'b00) begin
          $display("FAIL mode_updown_quiet: press %0d edge %0d got up=%b down=%b expected 0/0", p, k, btn_up, btn_down);
          errors++;
        end
        if (k == 6) begin
          checks++;
          if (mode !== old_m) begin
            $display("FAIL mode_before: press %0d got %0d expected %0d", p, mode, old_m);
            errors++;
          end
        end
        if (k == 7) begin
          checks++;
          if (mode !== new_m) begin
            $display("FAIL mode_step: press %0d got %0d expected %0d", p, mode, new_m);
            errors++;
          end
        end
      end
      $display("mode press %0d: mode=%0d", p, mode);
      old_m = new_m;
    end
  endtask

  task automatic test_up_repeat();
    logic exp_up;
    int   npulse;
    press_mode();
    checks++;
    if (mode !== 3'd2) begin
      $display("FAIL up_mode_setup: got %0d expected 2", mode);
      errors++;
    end
    npulse = 0;
    btn_up_raw = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 60) btn_up_raw = 1'b0;
      exp_up = (e == 6) || (e >= 26 && e <= 61 && ((e - 26) % 5) == 0);
      if (btn_up === 1'b1) npulse++;
      checks++;
      if ({btn_up, btn_down} !== {exp_up, 1'b0}) begin
        $display("FAIL up_repeat: edge %0d got up=%b down=%b expected %b/0", e, btn_up, btn_down, exp_up);
        errors++;
      end
    end
    $display("up repeat: %0d pulses", npulse);
  endtask

  task automatic test_down_glitch();
    logic exp_dn;
    press_mode();
    checks++;
    if (mode !== 3'd3) begin
      $display("FAIL glitch_mode_setup: got %0d expected 3", mode);
      errors++;
    end
    btn_down_raw = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 3) btn_down_raw = 1'b0;
      checks++;
      if ({btn_up, btn_down} !== 2'b00) begin
        $display("FAIL down_glitch: edge %0d got up=%b down=%b expected 0/0", e, btn_up, btn_down);
        errors++;
      end
    end
    btn_down_raw = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 8) btn_down_raw = 1'b0;
      exp_dn = (e == 6);
      checks++;
      if ({btn_up, btn_down} !== {1'b0, exp_dn}) begin
        $display("FAIL down_single: edge %0d got up=%b down=%b expected 0/%b", e, btn_up, btn_down, exp_dn);
        errors++;
      end
    end
    $display("down glitch + short hold done: mode=%0d", mode);
  endtask

  task automatic test_run_gating();
    logic exp_up;
    repeat (4) press_mode();
    checks++;
    if (mode !== 3'd0) begin
      $display("FAIL run_mode_setup: got %0d expected 0", mode);
      errors++;
    end
    btn_up_raw = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({btn_up, btn_down} !== 2'b00) begin
        $display("FAIL run_gated: edge %0d got up=%b down=%b expected 0/0", e, btn_up, btn_down);
        errors++;
      end
    end
    btn_mode_raw = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 10) btn_mode_raw = 1'b0;
      checks++;
      if ({btn_up, btn_down} !== 2'b00) begin
        $display("FAIL held_no_carry: edge %0d got up=%b down=%b expected 0/0", e, btn_up, btn_down);
        errors++;
      end
    end
    checks++;
    if (mode !== 3'd1) begin
      $display("FAIL run_to_sec: got %0d expected 1", mode);
      errors++;
    end
    btn_up_raw = 1'b0;
    repeat (15) @(negedge clk);
    btn_up_raw = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 10) btn_up_raw = 1'b0;
      exp_up = (e == 6);
      checks++;
      if ({btn_up, btn_down} !== {exp_up, 1'b0}) begin
        $display("FAIL repress_after_mode: edge %0d got up=%b down=%b expected %b/0", e, btn_up, btn_down, exp_up);
        errors++;
      end
    end
    repeat (10) @(negedge clk);
    $display("run gating done: mode=%0d", mode);
  endtask

  task automatic test_both_pressed();
    logic exp_up;
    logic exp_dn;
    repeat (3) press_mode();
    checks++;
    if (mode !== 3'd4) begin
      $display("FAIL both_mode_setup: got %0d expected 4", mode);
      errors++;
    end
    btn_up_raw = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 10) btn_down_raw = 1'b1;
      exp_up = (e == 6);
      checks++;
      if ({btn_up, btn_down} !== {exp_up, 1'b0}) begin
        $display("FAIL both_suppress: edge %0d got up=%b down=%b expected %b/0", e, btn_up, btn_down, exp_up);
        errors++;
      end
    end
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({btn_up, btn_down} !== 2'b00) begin
        $display("FAIL both_release: edge %0d got up=%b down=%b expected 0/0", e, btn_up, btn_down);
        errors++;
      end
    end
    btn_down_raw = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 10) btn_down_raw = 1'b0;
      exp_dn = (e == 6);
      checks++;
      if ({btn_up, btn_down} !== {1'b0, exp_dn}) begin
        $display("FAIL down_after_both: edge %0d got up=%b down=%b expected 0/%b", e, btn_up, btn_down, exp_dn);
        errors++;
      end
    end
    $display("both pressed done: mode=%0d", mode);
  endtask

  task automatic test_reset_midhold();
    logic exp_up;
    press_mode();
    checks++;
    if (mode !== 3'd5) begin
      $display("FAIL midhold_mode_setup: got %0d expected 5", mode);
      errors++;
    end
    btn_up_raw = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_up = (e == 6);
      checks++;
      if ({btn_up, btn_down} !== {exp_up, 1'b0}) begin
        $display("FAIL midhold_first: edge %0d got up=%b down=%b expected %b/0", e, btn_up, btn_down, exp_up);
        errors++;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mode, btn_up, btn_down} !== 5'b0) begin
      $display("FAIL midhold_async_reset: got mode=%0d up=%b down=%b expected 0/0/0", mode, btn_up, btn_down);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mode, btn_up, btn_down} !== 5'b0) begin
        $display("FAIL post_reset_hold: edge %0d got mode=%0d up=%b down=%b expected 0/0/0", e, mode, btn_up, btn_down);
        errors++;
      end
    end
    btn_up_raw = 1'b0;
    repeat (10) @(negedge clk);
    $display("reset mid-hold done: mode=%0d", mode);
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_up_repeat();
    test_down_glitch();
    test_run_gating();
    test_both_pressed();
    test_reset_midhold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_input_ctrl.md
Name: button_input_ctrl

Overview:
User-input front end of the clock. Synchronises and debounces the three raw push-buttons (mode, up, down). Produces the `mode[2:0]` selector and single-cycle `btn_up`/`btn_down` pulses, with hold-to-auto-repeat, that drive the second/minute/hour/day/month/year counters. It sits between the board pins and the counter chain, and is instantiated beside the clock generator in the top level.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive synchronised-stable cycles before a debounced level change is accepted (min 2).
- REPEAT_DELAY, 25000000: cycles from the first pulse of a held up/down button to its first auto-repeat pulse.
- REPEAT_PERIOD, 5000000: cycles between successive auto-repeat pulses.
- NUM_MODES, 7: number of mode values; mode wraps from NUM_MODES-1 to 0.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- btn_mode_raw, input, 1: raw mode button, active-high, asynchronous.
- btn_up_raw, input, 1: raw up button, active-high, asynchronous.
- btn_down_raw, input, 1: raw down button, active-high, asynchronous.
- mode, output, 3: current edit mode. 0=run, 1=sec, 2=min, 3=hour, 4=day, 5=month, 6=year.
- btn_up, output, 1: one-cycle increment pulse.
- btn_down, output, 1: one-cycle decrement pulse.

Behaviour:
- Reset (async, rst_n=0):
  - mode=0, btn_up=0, btn_down=0.
  - Synchronisers, debounced levels, counters and FSMs all cleared.
  - Deasserting reset while a button is held: the hold counts as a new press once debounced.
- Per button:
  - 2-flop synchroniser, then debounce counter.
  - The counter increments on every edge where the synced level differs from the debounced level, and clears whenever they match.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
- Latency: if raw is first sampled high at edge 1 and stays high, the debounced level and the press pulse take effect at edge DEBOUNCE_CYCLES+2. The output pulse is registered and high for exactly the following cycle.
- Glitches: any raw glitch shorter than DEBOUNCE_CYCLES cycles produces no output.
- Mode:
  - Each debounced mode press increments mode, wrapping 6->0 for the default NUM_MODES.
  - Mode releases have no effect.
- Up/down repeat FSM (one per button): states IDLE, DELAY, REPEAT.
  - IDLE: on a debounced press, emit a pulse, clear the timer, go to DELAY.
  - DELAY: after REPEAT_DELAY cycles still held, emit a pulse, clear the timer, go to REPEAT.
  - REPEAT: emit a pulse every REPEAT_PERIOD cycles while held.
  - Debounced release in any state: go to IDLE immediately, with no pulse on the release edge.
- Gating:
  - When mode==0 (run), btn_up and btn_down are forced to 0; the FSMs still track the buttons.
  - If up and down are both debounced-pressed, both outputs are suppressed and both FSMs return to IDLE. They stay there until each button has been released and pressed again.
  - A mode press while up or down is held forces that FSM to IDLE. No further pulses occur until release and a new press, so a held button never carries into the next field.
- Simultaneous events in one cycle:
  - Mode press plus up/down press: mode updates and the up/down pulse is dropped.
  - btn_up and btn_down are never both 1 in the same cycle.
- Timers are sized to ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD))+1) bits. The debounce counter is sized to ceil(log2(DEBOUNCE_CYCLES)+1) bits. No counter wraps before terminal count.

Decomposition:
- Shared package (clock_pkg) holds:
  - mode encoding constants: MODE_RUN=0, MODE_SEC=1, MODE_MIN=2, MODE_HOUR=3, MODE_DAY=4, MODE_MONT=5, MODE_YEAR=6;
  - NUM_MODES;
  - repeat FSM state encoding: IDLE, DELAY, REPEAT.
- One sub-module, btn_debounce:
  - contains the synchroniser, the debounce counter and the registered rising/falling event flags;
  - parameter DEBOUNCE_CYCLES;
  - instantiated three times.
- Mode register and repeat FSMs live in button_input_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, NUM_MODES=7):
1. Reset, then press mode 8 times, each press 10 cycles held and 10 released -> mode steps 1,2,3,4,5,6,0,1. btn_up/btn_down stay 0 throughout.
2. Mode=2, btn_up_raw high from edge 1 for 60 cycles -> btn_up pulses after edges 6, 26, 31, 36, 41, 46, 51, 56, 61 (each 1 cycle). No pulse after release.
3. Mode=3, btn_down_raw glitch high for 3 cycles, then low for 10 -> no pulse. Then hold for 8 cycles -> exactly one btn_down pulse, after edge 6 of that hold.
4. Mode=0, hold btn_up_raw 50 cycles -> btn_up stays 0. Set mode=1 while up is still held -> still no pulse until up is released and pressed again.
5. Mode=4, hold up (first pulse seen), then assert down 10 cycles later -> no further up or down pulses. Release both and press down -> a single btn_down pulse.
6. Mode=5, hold up 15 cycles, then assert rst_n=0 for 1 cycle mid-hold -> mode=0 and outputs 0 immediately (asynchronously). After reset, the held up in mode 0 produces no pulse.
